// File: rtl/video_timing_pkg.sv
// Shared timing types and presets for the raster timing generator.
//   timing_t : one axis of raster geometry (visible/front/sync/back)
//   mode_t   : horizontal plus vertical geometry
//   total()  : full period of one axis
package video_timing_pkg;

  typedef struct packed {
    int unsigned visible;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } timing_t;

  typedef struct packed {
    timing_t h;
    timing_t v;
  } mode_t;

  // Raw counters are 10 bits wide, so neither axis may exceed this period.
  localparam int unsigned MaxTotal = 1024;

  localparam mode_t VGA_320x480 = '{
    h: '{visible: 320, front: 8,  sync: 48, back: 24},
    v: '{visible: 480, front: 10, sync: 2,  back: 33}
  };

  localparam mode_t VGA_640x480 = '{
    h: '{visible: 640, front: 16, sync: 96, back: 48},
    v: '{visible: 480, front: 10, sync: 2,  back: 33}
  };

  function automatic int unsigned total(timing_t t);
    return t.visible + t.front + t.sync + t.back;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Output bundle of the raster timing generator.
//   master : driven by video_timing_gen
//   slave  : consumed by the pixel pipeline / VGA pin logic
// hcounter/vcounter/row and the strobes are undelayed; hsync/vsync/visible
// are delayed by the generator's PIPE_DEPTH.
interface video_timing_gen_if #(
  parameter int unsigned FRAME_W = 8
);
  logic [9:0]         hcounter;
  logic [9:0]         vcounter;
  logic [9:0]         row;
  logic               line_start;
  logic               frame_start;
  logic               vblank_irq;
  logic               writable;
  logic [FRAME_W-1:0] frame_count;
  logic               hsync;
  logic               vsync;
  logic               visible;

  modport master (
    output hcounter, vcounter, row, line_start, frame_start, vblank_irq,
           writable, frame_count, hsync, vsync, visible
  );

  modport slave (
    input hcounter, vcounter, row, line_start, frame_start, vblank_irq,
          writable, frame_count, hsync, vsync, visible
  );
endinterface

// File: rtl/sig_delay.sv
// WIDTH-bit shift register of DEPTH stages with synchronous reset.
//   clk_12_5875 : clock
//   rst         : synchronous active-high reset, loads RESET_VAL in all stages
//   d / q       : input and DEPTH-cycle delayed output
// DEPTH=0 degenerates to a wire that is forced to RESET_VAL while rst is high.
module sig_delay #(
  parameter int unsigned     WIDTH     = 1,
  parameter int unsigned     DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_12_5875,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_comb
    logic unused_clk;
    assign unused_clk = clk_12_5875;
    assign q = rst ? RESET_VAL : d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_12_5875) begin
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
      end else begin
        stage_q[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator.
//   clk_12_5875 : pixel clock
//   rst         : synchronous active-high reset
//   tim         : timing bundle (master); raw counters, row, line/frame/vblank
//                 strobes, writable window and frame counter are undelayed;
//                 hsync/vsync/visible pass through a PIPE_DEPTH-stage delay
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE    = VGA_320x480.h.visible,
  parameter int unsigned H_FRONT      = VGA_320x480.h.front,
  parameter int unsigned H_SYNC       = VGA_320x480.h.sync,
  parameter int unsigned H_BACK       = VGA_320x480.h.back,
  parameter int unsigned V_VISIBLE    = VGA_320x480.v.visible,
  parameter int unsigned V_FRONT      = VGA_320x480.v.front,
  parameter int unsigned V_SYNC       = VGA_320x480.v.sync,
  parameter int unsigned V_BACK       = VGA_320x480.v.back,
  parameter bit          HSYNC_ACTIVE = 1'b0,
  parameter bit          VSYNC_ACTIVE = 1'b0,
  parameter int unsigned PIPE_DEPTH   = 2,
  parameter int unsigned V_SCALE_LOG2 = 1,
  parameter int unsigned FRAME_W      = 8
) (
  input logic                clk_12_5875,
  input logic                rst,
  video_timing_gen_if.master tim
);

  localparam timing_t HTiming = '{visible: H_VISIBLE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
  localparam timing_t VTiming = '{visible: V_VISIBLE, front: V_FRONT, sync: V_SYNC, back: V_BACK};
  localparam int unsigned HTotal = total(HTiming);
  localparam int unsigned VTotal = total(VTiming);

  // 11-bit decode constants so a full 1024-clock period still compares correctly.
  localparam logic [10:0] HLast      = 11'(HTotal - 1);
  localparam logic [10:0] VLast      = 11'(VTotal - 1);
  localparam logic [10:0] HVis       = 11'(H_VISIBLE);
  localparam logic [10:0] VVis       = 11'(V_VISIBLE);
  localparam logic [10:0] HSyncStart = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HSyncEnd   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VSyncStart = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VSyncEnd   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  if (HTotal > MaxTotal) begin : g_chk_htotal
    $error("video_timing_gen: horizontal total %0d exceeds %0d", HTotal, MaxTotal);
  end
  if (VTotal > MaxTotal) begin : g_chk_vtotal
    $error("video_timing_gen: vertical total %0d exceeds %0d", VTotal, MaxTotal);
  end
  if (PIPE_DEPTH > 7) begin : g_chk_depth
    $error("video_timing_gen: PIPE_DEPTH %0d exceeds 7", PIPE_DEPTH);
  end

  logic [9:0]         hcnt_q;
  logic [9:0]         vcnt_q;
  logic [FRAME_W-1:0] frame_count_q;
  logic [10:0]        h_ext;
  logic [10:0]        v_ext;
  logic               h_last;
  logic               v_last;

  assign h_ext  = {1'b0, hcnt_q};
  assign v_ext  = {1'b0, vcnt_q};
  assign h_last = (h_ext == HLast);
  assign v_last = (v_ext == VLast);

  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      frame_count_q <= '0;
    end else if (h_last) begin
      hcnt_q <= '0;
      if (v_last) begin
        vcnt_q        <= '0;
        frame_count_q <= frame_count_q + 1'b1;
      end else begin
        vcnt_q <= vcnt_q + 10'd1;
      end
    end else begin
      hcnt_q <= hcnt_q + 10'd1;
    end
  end

`ifdef SIM
  always_ff @(posedge clk_12_5875) begin
    if (!rst && h_last && v_last) begin
      $display("video_timing_gen: frame %0d complete", frame_count_q + 1'b1);
    end
  end
`endif

  // Raw (undelayed) sync and visible decodes, converted to output levels.
  logic hsync_on;
  logic vsync_on;
  logic visible_raw;
  logic [2:0] bundle_raw;
  logic [2:0] bundle_dly;

  assign hsync_on    = (h_ext >= HSyncStart) && (h_ext < HSyncEnd);
  assign vsync_on    = (v_ext >= VSyncStart) && (v_ext < VSyncEnd);
  assign visible_raw = (h_ext < HVis) && (v_ext < VVis);
  assign bundle_raw  = {hsync_on ? HSYNC_ACTIVE : !HSYNC_ACTIVE,
                        vsync_on ? VSYNC_ACTIVE : !VSYNC_ACTIVE,
                        visible_raw};

  sig_delay #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DEPTH),
    .RESET_VAL ({!HSYNC_ACTIVE, !VSYNC_ACTIVE, 1'b0})
  ) u_sig_delay (
    .clk_12_5875 (clk_12_5875),
    .rst         (rst),
    .d           (bundle_raw),
    .q           (bundle_dly)
  );

  assign tim.hsync       = bundle_dly[2];
  assign tim.vsync       = bundle_dly[1];
  assign tim.visible     = bundle_dly[0];
  assign tim.hcounter    = hcnt_q;
  assign tim.vcounter    = vcnt_q;
  assign tim.frame_count = frame_count_q;

  // Zero-latency decodes; held quiet (writable held open) while in reset.
  assign tim.row         = rst ? 10'd0 : (vcnt_q >> V_SCALE_LOG2);
  assign tim.line_start  = !rst && (hcnt_q == 10'd0);
  assign tim.frame_start = !rst && (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
  assign tim.vblank_irq  = !rst && (hcnt_q == 10'd0) && (v_ext == VVis);
  assign tim.writable    = rst || (v_ext >= VVis);

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen using a reduced 16x10 raster so several frames fit
// in a short run. Geometry: H 8/2/3/3 (hsync at h 10..12), V 6/1/2/1 (vsync at
// v 7..8, vblank at v 6), frame = 160 clocks.
//   dut_a : PIPE_DEPTH=2, active-low syncs, row = v >> 1
//   dut_b : PIPE_DEPTH=0, active-high syncs
//   dut_c : PIPE_DEPTH=5, active-low syncs
// k counts clock edges since reset release (k=0 is the first cycle at (0,0)).
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  video_timing_gen_if #(.FRAME_W(3)) ifa ();
  video_timing_gen_if #(.FRAME_W(3)) ifb ();
  video_timing_gen_if #(.FRAME_W(3)) ifc ();

  video_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0),
    .PIPE_DEPTH(2), .V_SCALE_LOG2(1), .FRAME_W(3)
  ) dut_a (.clk_12_5875(clk), .rst(rst), .tim(ifa));

  video_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_ACTIVE(1'b1), .VSYNC_ACTIVE(1'b1),
    .PIPE_DEPTH(0), .V_SCALE_LOG2(0), .FRAME_W(3)
  ) dut_b (.clk_12_5875(clk), .rst(rst), .tim(ifb));

  video_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0),
    .PIPE_DEPTH(5), .V_SCALE_LOG2(1), .FRAME_W(3)
  ) dut_c (.clk_12_5875(clk), .rst(rst), .tim(ifc));

  typedef struct {
    int cyc;
    int h, v, row, ls, fs, vb, wr, fc;
    int a_hs, a_vs, a_vis;
    int b_hs, b_vs, b_vis;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s (k=%0d): got %0d expected %0d", name, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    k = 0;
  endtask

  int first_a, first_b, first_c, hdiff;
  int a_hs_n, a_vs_n, b_hs_n, b_vs_n, vb_n, ls_n, fs_n, a_hs_first, a_vs_first;

  initial begin
    //            cyc  h  v row ls fs vb wr fc  A:hs vs vis  B:hs vs vis
    vecs.push_back('{0,   0, 0, 0, 1, 1, 0, 0, 0,  1, 1, 0,  0, 0, 1});
    vecs.push_back('{1,   1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 0, 1});
    vecs.push_back('{2,   2, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1,  0, 0, 1});
    vecs.push_back('{8,   8, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1,  0, 0, 0});
    vecs.push_back('{10, 10, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  1, 0, 0});
    vecs.push_back('{12, 12, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,  1, 0, 0});
    vecs.push_back('{13, 13, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,  0, 0, 0});
    vecs.push_back('{15, 15, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 0, 0});
    vecs.push_back('{16,  0, 1, 0, 1, 0, 0, 0, 0,  1, 1, 0,  0, 0, 1});
    vecs.push_back('{32,  0, 2, 1, 1, 0, 0, 0, 0,  1, 1, 0,  0, 0, 1});
    vecs.push_back('{96,  0, 6, 3, 1, 0, 1, 1, 0,  1, 1, 0,  0, 0, 0});
    vecs.push_back('{97,  1, 6, 3, 0, 0, 0, 1, 0,  1, 1, 0,  0, 0, 0});
    vecs.push_back('{112, 0, 7, 3, 1, 0, 0, 1, 0,  1, 1, 0,  0, 1, 0});
    vecs.push_back('{114, 2, 7, 3, 0, 0, 0, 1, 0,  1, 0, 0,  0, 1, 0});
    vecs.push_back('{140,12, 8, 4, 0, 0, 0, 1, 0,  0, 0, 0,  1, 1, 0});
    vecs.push_back('{144, 0, 9, 4, 1, 0, 0, 1, 0,  1, 0, 0,  0, 0, 0});
    vecs.push_back('{146, 2, 9, 4, 0, 0, 0, 1, 0,  1, 1, 0,  0, 0, 0});
    vecs.push_back('{159,15, 9, 4, 0, 0, 0, 1, 0,  1, 1, 0,  0, 0, 0});
    vecs.push_back('{160, 0, 0, 0, 1, 1, 0, 0, 1,  1, 1, 0,  0, 0, 1});
    vecs.push_back('{162, 2, 0, 0, 0, 0, 0, 0, 1,  1, 1, 1,  0, 0, 1});

    // Table-driven walk through the first frame and into the second.
    do_reset();
    foreach (vecs[i]) begin
      while (k < vecs[i].cyc) step();
      chk("hcounter",    int'(ifa.hcounter),    vecs[i].h);
      chk("vcounter",    int'(ifa.vcounter),    vecs[i].v);
      chk("row",         int'(ifa.row),         vecs[i].row);
      chk("line_start",  int'(ifa.line_start),  vecs[i].ls);
      chk("frame_start", int'(ifa.frame_start), vecs[i].fs);
      chk("vblank_irq",  int'(ifa.vblank_irq),  vecs[i].vb);
      chk("writable",    int'(ifa.writable),    vecs[i].wr);
      chk("frame_count", int'(ifa.frame_count), vecs[i].fc);
      chk("a_hsync",     int'(ifa.hsync),       vecs[i].a_hs);
      chk("a_vsync",     int'(ifa.vsync),       vecs[i].a_vs);
      chk("a_visible",   int'(ifa.visible),     vecs[i].a_vis);
      chk("b_hsync",     int'(ifb.hsync),       vecs[i].b_hs);
      chk("b_vsync",     int'(ifb.vsync),       vecs[i].b_vs);
      chk("b_visible",   int'(ifb.visible),     vecs[i].b_vis);
    end

    // Visible latency after frame_start for depths 0, 2 and 5; counters match.
    do_reset();
    chk("frame_start_b", int'(ifb.frame_start), 1);
    chk("frame_start_c", int'(ifc.frame_start), 1);
    first_a = -1; first_b = -1; first_c = -1; hdiff = 0;
    for (int i = 0; i < 16; i++) begin
      if (first_a < 0 && ifa.visible) first_a = k;
      if (first_b < 0 && ifb.visible) first_b = k;
      if (first_c < 0 && ifc.visible) first_c = k;
      if (ifa.hcounter != ifb.hcounter || ifa.hcounter != ifc.hcounter) hdiff++;
      step();
    end
    chk("vis_latency_d0", first_b, 0);
    chk("vis_latency_d2", first_a, 2);
    chk("vis_latency_d5", first_c, 5);
    chk("hcounter_match", hdiff, 0);

    // Whole-frame pulse widths and placements.
    do_reset();
    a_hs_n = 0; a_vs_n = 0; b_hs_n = 0; b_vs_n = 0; vb_n = 0; ls_n = 0; fs_n = 0;
    a_hs_first = -1; a_vs_first = -1;
    for (int i = 0; i < 160; i++) begin
      if (!ifa.hsync) begin
        a_hs_n++;
        if (a_hs_first < 0) a_hs_first = k;
      end
      if (!ifa.vsync) begin
        a_vs_n++;
        if (a_vs_first < 0) a_vs_first = k;
      end
      if (ifb.hsync) b_hs_n++;
      if (ifb.vsync) b_vs_n++;
      if (ifa.vblank_irq) vb_n++;
      if (ifa.line_start) ls_n++;
      if (ifa.frame_start) fs_n++;
      step();
    end
    chk("a_hsync_low_clocks",  a_hs_n, 30);
    chk("a_vsync_low_clocks",  a_vs_n, 32);
    chk("b_hsync_high_clocks", b_hs_n, 30);
    chk("b_vsync_high_clocks", b_vs_n, 32);
    chk("a_hsync_first_low",   a_hs_first, 12);
    chk("a_vsync_first_low",   a_vs_first, 114);
    chk("vblank_irq_pulses",   vb_n, 1);
    chk("line_start_pulses",   ls_n, 10);
    chk("frame_start_pulses",  fs_n, 1);

    // Frame counter wraps 7 -> 0 with FRAME_W=3.
    do_reset();
    while (k < 1120) step();
    chk("fc_frame7", int'(ifa.frame_count), 7);
    while (k < 1279) step();
    chk("fc_before_wrap", int'(ifa.frame_count), 7);
    step();
    chk("fc_wrap", int'(ifa.frame_count), 0);
    chk("fc_wrap_fs", int'(ifa.frame_start), 1);

    // Reset asserted mid-frame while hsync is active (h=12, v=3).
    do_reset();
    while (k < 60) step();
    chk("mid_a_hsync_active", int'(ifa.hsync), 0);
    chk("mid_b_hsync_active", int'(ifb.hsync), 1);
    rst = 1'b1;
    #1;
    chk("rst_b_hsync_gated", int'(ifb.hsync), 0);
    chk("rst_b_visible_gated", int'(ifb.visible), 0);
    chk("rst_writable", int'(ifa.writable), 1);
    chk("rst_row", int'(ifa.row), 0);
    chk("rst_line_start", int'(ifa.line_start), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hcounter", int'(ifa.hcounter), 0);
      chk("rst_vcounter", int'(ifa.vcounter), 0);
      chk("rst_a_hsync",  int'(ifa.hsync), 1);
      chk("rst_a_vsync",  int'(ifa.vsync), 1);
      chk("rst_a_visible", int'(ifa.visible), 0);
      chk("rst_frame_start", int'(ifa.frame_start), 0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_frame_start", int'(ifa.frame_start), 1);
    chk("post_rst_frame_count", int'(ifa.frame_count), 0);
    chk("post_rst_b_visible", int'(ifb.visible), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator. It is the successor to the fixed 320x480 timing block and drives the GPU pixel pipeline and the VGA pins. It provides configurable porch/sync geometry and sync polarity, plus a programmable output delay pipeline so sync/visible line up with downstream pixel fetch latency. It also adds line/frame strobes, a vertically-scaled logical row, a frame counter and a CPU-writable window with an early-warning vblank interrupt.

Parameters:
H_VISIBLE, 320, active pixels per line
H_FRONT, 8, horizontal front porch (clocks)
H_SYNC, 48, hsync width (clocks)
H_BACK, 24, horizontal back porch; H_TOTAL = sum = 400
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch; V_TOTAL = sum = 525
HSYNC_ACTIVE, 0, hsync asserted level
VSYNC_ACTIVE, 0, vsync asserted level
PIPE_DEPTH, 2, cycles of delay on hsync/vsync/visible (0..7)
V_SCALE_LOG2, 1, logical row = vcounter >> V_SCALE_LOG2
FRAME_W, 8, frame counter width

Ports:
clk_12_5875  in  1  pixel clock
rst  in  1  reset, synchronous, active-high
hcounter  out  10  raw horizontal position, undelayed
vcounter  out  10  raw vertical line, undelayed
row  out  10  vcounter >> V_SCALE_LOG2, zero-extended
line_start  out  1  1-cycle pulse when hcounter==0
frame_start  out  1  1-cycle pulse when hcounter==0 && vcounter==0
vblank_irq  out  1  1-cycle pulse when hcounter==0 && vcounter==V_VISIBLE
writable  out  1  vcounter >= V_VISIBLE (undelayed)
frame_count  out  FRAME_W  frames completed since reset, wraps
hsync  out  1  delayed by PIPE_DEPTH
vsync  out  1  delayed by PIPE_DEPTH
visible  out  1  delayed by PIPE_DEPTH

Behaviour:
- Counters: hcounter 0..H_TOTAL-1, then wraps to 0. vcounter advances only when hcounter==H_TOTAL-1 and wraps from V_TOTAL-1 to 0.
- hsync_raw asserted for H_VISIBLE+H_FRONT <= hcounter < H_VISIBLE+H_FRONT+H_SYNC. vsync_raw uses the same rule on vcounter with V_ params. The output level equals *_ACTIVE when asserted and its complement otherwise.
- visible_raw = (hcounter < H_VISIBLE) && (vcounter < V_VISIBLE).
- Delay pipeline: each of hsync/vsync/visible passes through a PIPE_DEPTH-stage shift register. With PIPE_DEPTH=0 these outputs are combinational decodes, gated inactive during rst.
- Strobes, row and writable are decoded from raw counters (zero delay). They are combinational, and forced to 0 (writable: 1) while rst is high.
- frame_count increments on the edge where vcounter wraps V_TOTAL-1 -> 0 and wraps at 2^FRAME_W.
- Reset values:
  - hcounter=0, vcounter=0, frame_count=0.
  - All delay stages hold visible=0 and sync=inactive level.
  - Strobes 0.
- First post-reset cycle: counters read (0,0), so line_start=frame_start=1 in that cycle. visible rises PIPE_DEPTH cycles later.
- Reset mid-frame: counters return to 0 on the next edge, and the pipeline flushes to inactive in the same edge. No partial sync pulse is emitted after rst rises, other than the edge on which rst is sampled.
- Elaboration checks: H_TOTAL and V_TOTAL must be <= 1024, and PIPE_DEPTH must be <= 7. An $error is raised otherwise.
- Under `SIM, a message is displayed on each frame wrap.

Decomposition:
- Package video_timing_pkg: a timing_t struct (visible/front/sync/back), localparam presets VGA_320x480 and VGA_640x480, and a function total(timing_t).
- One sub-module, sig_delay (parametrised WIDTH, DEPTH, RESET_VAL shift register). It is instanced once, with WIDTH=3, for the hsync/vsync/visible bundle.

Test Plan:
1. Default params, release rst, run 2 frames:
   - hsync low for exactly 48 clocks starting 330 clocks after line_start (328+PIPE_DEPTH).
   - Line period 400 clocks; frame period 210000 clocks.
2. vsync timing:
   - vsync low for exactly 800 clocks per frame, beginning at raw vcounter=490, hcounter=0, +2 clocks.
   - vblank_irq pulses once per frame at vcounter=480, hcounter=0.
3. PIPE_DEPTH=0 vs 5: visible rising edge occurs 0 and 5 clocks after frame_start respectively. hcounter is identical in both.
4. HSYNC_ACTIVE=1, VSYNC_ACTIVE=1: sync pulses are high, idle low; widths unchanged.
5. V_SCALE_LOG2=1: row=0 on vcounter 0 and 1, row=239 on vcounter 478 and 479. frame_count goes 0->1->2 over 2 frames and wraps 255->0 (FRAME_W=8).
6. Assert rst for 3 clocks at hcounter=200, vcounter=100:
   - Next edge gives counters 0, visible=0, hsync/vsync high.
   - After release, frame_start fires and frame_count=0.
